// File: rtl/grid_sequencer_if.sv
// Pattern stream handshake carrying one 2-bit cell state per beat into grid_sequencer.
interface grid_sequencer_if;
   logic       patValid;
   logic [1:0] patData;
   logic       patReady;

   modport master (output patValid, output patData, input patReady);
   modport slave  (input patValid, input patData, output patReady);
endinterface

// File: rtl/grid_sequencer.sv
// Cellular-grid sequencer: streams a pattern into the cells, then clocks generations.
// Optional generation limit enabled by defining GRID_SEQUENCER_GEN_LIMIT_EN.
module grid_sequencer #(
   parameter int CELLS = 64,
   parameter int DIV   = 4,
   parameter int GEN_W = 16
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     start,
   input  logic                     stop,
   grid_sequencer_if.slave          pat,
   input  logic [GEN_W-1:0]         maxGen,
   output logic [$clog2(CELLS)-1:0] loadAddr,
   output logic [1:0]               loadVal,
   output logic                     load,
   output logic                     dividedClock,
   output logic                     enTimeStep,
   output logic [GEN_W-1:0]         generation,
   output logic                     done,
   output logic [1:0]               state
);

   localparam int AW = $clog2(CELLS);
   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

   localparam logic [1:0]       ST_IDLE   = 2'd0;
   localparam logic [1:0]       ST_LOAD   = 2'd1;
   localparam logic [1:0]       ST_RUN    = 2'd2;
   localparam logic [AW-1:0]    LAST_ADDR = AW'(CELLS - 1);
   localparam logic [AW-1:0]    ADDR_ONE  = AW'(1);
   localparam logic [CW-1:0]    CNT_TOP   = CW'(DIV - 1);
   localparam logic [CW-1:0]    CNT_ONE   = CW'(1);
   localparam logic [GEN_W-1:0] GEN_ONE   = GEN_W'(1);

   logic [1:0]       state_r;
   logic [1:0]       state_nxt_s;
   logic [AW-1:0]    addr_r;
   logic [AW-1:0]    addr_s;
   logic [1:0]       val_r;
   logic [1:0]       val_s;
   logic             load_r;
   logic             load_s;
   logic             div_clk_r;
   logic             div_s;
   logic             en_step_r;
   logic             en_s;
   logic [GEN_W-1:0] gen_r;
   logic [GEN_W-1:0] gen_s;
   logic [GEN_W-1:0] gen_inc_s;
   logic             done_r;
   logic             done_s;
   logic             ready_r;
   logic             ready_s;
   logic [CW-1:0]    cnt_r;
   logic [CW-1:0]    cnt_s;
   logic             limit_hit_s;
   logic             limit_stop_s;

   assign gen_inc_s = gen_r + GEN_ONE;

`ifdef GRID_SEQUENCER_GEN_LIMIT_EN
   // done is registered alongside the limiting increment; the FSM leaves RUN on the cycle after
   assign limit_hit_s  = (maxGen != {GEN_W{1'b0}}) && (gen_inc_s == maxGen);
   assign limit_stop_s = done_r;
`else
   logic unused_max_gen_s;
   assign unused_max_gen_s = ^maxGen;
   assign limit_hit_s      = 1'b0;
   assign limit_stop_s     = 1'b0;
`endif

   // State register
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state decode; stop outranks start and completion
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (start && !stop) begin
               state_nxt_s = ST_LOAD;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_LOAD: begin
            if (stop) begin
               state_nxt_s = ST_IDLE;
            end else if (div_clk_r && (addr_r == LAST_ADDR)) begin
               state_nxt_s = ST_RUN;
            end else begin
               state_nxt_s = ST_LOAD;
            end
         end
         ST_RUN: begin
            if (stop || limit_stop_s) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_RUN;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // Next values of the registered outputs, divider and load address
   always_comb begin
      addr_s  = addr_r;
      val_s   = val_r;
      load_s  = 1'b0;
      div_s   = 1'b0;
      en_s    = 1'b0;
      gen_s   = gen_r;
      done_s  = 1'b0;
      ready_s = 1'b0;
      cnt_s   = {CW{1'b0}};
      case (state_r)
         ST_IDLE: begin
            if (start && !stop) begin
               addr_s  = {AW{1'b0}};
               gen_s   = {GEN_W{1'b0}};
               ready_s = 1'b1;
            end else begin
               addr_s  = addr_r;
            end
         end
         ST_LOAD: begin
            if (stop) begin
               addr_s = {AW{1'b0}};
            end else if (div_clk_r) begin
               // Pulse cycle of an accepted beat: advance, or hand over to RUN after the last cell
               if (addr_r == LAST_ADDR) begin
                  addr_s = {AW{1'b0}};
                  load_s = 1'b1;
               end else begin
                  addr_s  = addr_r + ADDR_ONE;
                  ready_s = 1'b1;
               end
            end else if (pat.patValid && ready_r) begin
               val_s = pat.patData;
               div_s = 1'b1;
            end else begin
               ready_s = 1'b1;
            end
         end
         ST_RUN: begin
            if (stop || limit_stop_s) begin
               addr_s = {AW{1'b0}};
            end else begin
               load_s = 1'b1;
               if (cnt_r == CNT_TOP) begin
                  div_s = !div_clk_r;
                  // Each rising edge of the cell clock is one generation
                  if (!div_clk_r) begin
                     en_s   = 1'b1;
                     gen_s  = gen_inc_s;
                     done_s = limit_hit_s;
                  end else begin
                     en_s   = 1'b0;
                  end
               end else begin
                  cnt_s = cnt_r + CNT_ONE;
                  div_s = div_clk_r;
               end
            end
         end
         default: begin
            addr_s = {AW{1'b0}};
         end
      endcase
   end

   // Output and datapath registers
   always_ff @(posedge clock) begin
      if (!reset) begin
         addr_r    <= {AW{1'b0}};
         val_r     <= 2'b00;
         load_r    <= 1'b0;
         div_clk_r <= 1'b0;
         en_step_r <= 1'b0;
         gen_r     <= {GEN_W{1'b0}};
         done_r    <= 1'b0;
         ready_r   <= 1'b0;
         cnt_r     <= {CW{1'b0}};
      end else begin
         addr_r    <= addr_s;
         val_r     <= val_s;
         load_r    <= load_s;
         div_clk_r <= div_s;
         en_step_r <= en_s;
         gen_r     <= gen_s;
         done_r    <= done_s;
         ready_r   <= ready_s;
         cnt_r     <= cnt_s;
      end
   end

   assign pat.patReady = ready_r;
   assign loadAddr     = addr_r;
   assign loadVal      = val_r;
   assign load         = load_r;
   assign dividedClock = div_clk_r;
   assign enTimeStep   = en_step_r;
   assign generation   = gen_r;
   assign done         = done_r;
   assign state        = state_r;

endmodule
